// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle HI/LO multiply/divide sequencer beside the Execute stage
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        skip_q, skip_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, qu_mag, ru_mag, q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_neg  = rs[31];
  assign b_neg  = rt[31];
  assign b_zero = (rt == 32'd0);
  assign a_mag  = a_neg ? (32'd0 - rs) : rs;
  assign b_mag  = b_neg ? (32'd0 - rt) : rt;
  assign b_safe = b_zero ? 32'd1 : b_mag;
  assign qu_mag = a_mag / b_safe;
  assign ru_mag = a_mag % b_safe;
  assign q_s    = (a_neg ^ b_neg) ? (32'd0 - qu_mag) : qu_mag;
  assign r_s    = a_neg ? (32'd0 - ru_mag) : ru_mag;
  assign q_u    = rs / (b_zero ? 32'd1 : rt);
  assign r_u    = rs % (b_zero ? 32'd1 : rt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    skip_d    = skip_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
              skip_d  = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              pend_lo_d = (op == OP_DIV) ? q_s : q_u;
              pend_hi_d = (op == OP_DIV) ? r_s : r_u;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
              busy_d    = 1'b1;
              skip_d    = b_zero;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Flush and start are deliberately ignored: the in-flight op is past the exception point.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      skip_q    <= skip_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
